sdram_init_seq: RTL and testbench
=================================

// Module: sdram_init_seq
// PURPOSE
//   Parametrised SDRAM power-up initialisation sequencer; next generation of the fixed
//   50 MHz init block. Waits a programmable power-up delay, then issues PRECHARGE-ALL,
//   AREF_COUNT auto-refreshes and LOAD MODE REGISTER, each spaced by programmable cycles.
//   Sits beside the refresh/read/write arbiters and drives the shared command/address bus
//   until flag_init_end. Adds a run-time re-init request, which skips the power-up wait.
// PARAMETERS
//   PWRUP_CYCLES  10000     NOP cycles after reset before PRE (200 us at 50 MHz); >=1
//   TRP_CYCLES    2         cycles from PRE to first AREF; >=1
//   TRC_CYCLES    4         cycles from each AREF to next AREF or MRS; >=1
//   TMRD_CYCLES   2         cycles from MRS to flag_init_end; >=1
//   AREF_COUNT    2         number of AREF commands; >=1
//   ADDR_W        12        SDRAM address width; >=11 (A10 = precharge-all)
//   BA_W          2         bank address width
//   MODE_REG      12'h032   value on sdram_addr during MRS (CL=3, BL=4, sequential)
// PORTS
//   sclk           in   1       system clock
//   s_rst          in   1       asynchronous reset, active high
//   init_req       in   1       re-init request; sampled only when flag_init_end=1
//   cmd_reg        out  4       {CS_n,RAS_n,CAS_n,WE_n}: NOP=0111 PRE=0010 AREF=0001 MRS=0000
//   sdram_addr     out  ADDR_W  MODE_REG during MRS, else only A10 set (1<<10)
//   sdram_ba       out  BA_W    constant 0
//   flag_init_end  out  1       level: sequence complete, bus released
//   init_done      out  1       1-cycle pulse in the first cycle flag_init_end=1
//   init_busy      out  1       ~flag_init_end
// BEHAVIOUR
//   - Reset (async, any time incl. mid-sequence): state=WAIT, counters=0, cmd_reg=NOP,
//     flag_init_end=0, init_done=0; the full PWRUP_CYCLES wait restarts.
//   - Cycle numbering: cycle 0 = first sclk cycle after s_rst falls. All outputs are registered.
//   - FSM: WAIT -> PRE -> TRP -> AREF -> TRC -> (AREF | MRS) -> TMRD -> DONE.
//     WAIT: NOP, delay counter runs; PRE driven in cycle PWRUP_CYCLES.
//     PRE/AREF/MRS: command held exactly 1 cycle; all other cycles are NOP.
//     PRE in cycle P -> AREF #1 in P+TRP_CYCLES; AREF #k in A -> AREF #k+1 (k<AREF_COUNT)
//       or MRS (k=AREF_COUNT) in A+TRC_CYCLES; MRS in M -> flag_init_end=1 from M+TMRD_CYCLES.
//     DONE: NOP, flag_init_end=1, stays until reset or init_req.
//   - Defaults: PRE@10000, AREF@10002, AREF@10006, MRS@10010, flag_init_end=1 from 10012.
//   - Delay counter width $clog2(PWRUP_CYCLES+1); a shared gap counter sized for
//     max(TRP,TRC,TMRD); AREF counter width $clog2(AREF_COUNT+1). No wrap: counters
//     clear on every state entry.
//   - init_req=1 in DONE in cycle R: flag_init_end=0 in R+1; PRE driven in R+1; then
//     normal timing. init_req is ignored while busy; holding it high in DONE re-triggers
//     once per completed sequence.
//   - init_done pulses in the first DONE cycle of every completed sequence
//     (power-up and re-init).
//   - sdram_addr is a combinational decode of cmd_reg, so it is valid in the same cycle as
//     the command. Outside MRS it carries only A10 (precharge-all).
// TESTING
//   1 Defaults, reset release -> NOP in 0..9999; PRE@10000 (addr 0x400); AREF@10002,10006;
//     MRS@10010 (addr 0x032); flag_init_end and init_done at 10012; init_done low at 10013.
//   2 PWRUP=5, TRP=1, TRC=3, TMRD=1, AREF_COUNT=8 -> PRE@5, AREFs@6,9,..,27, MRS@30,
//     flag_init_end@31; exactly 8 AREFs counted.
//   3 Reset asserted at cycle 10004 (mid-AREF gap) -> cmd_reg=NOP immediately; after
//     release, PRE again exactly 10000 cycles later.
//   4 init_req pulse at DONE cycle R -> flag_init_end=0 at R+1, PRE at R+1, MRS at R+11,
//     done at R+13; init_req pulses during busy have no effect.
//   5 init_req held high -> back-to-back re-inits, each 13 cycles long, one init_done per
//     sequence; no command other than NOP/PRE/AREF/MRS ever appears.

Source files
------------

// File: rtl/sdram_init_seq.sv
// Purpose : SDRAM power-up / re-init sequencer: NOP wait, PRECHARGE-ALL, N x AUTO-REFRESH, LOAD MODE.
// Latency : PRE at cycle PWRUP_CYCLES after reset; a re-init issues PRE in the cycle after init_req.
// Backpr. : none; init_req is only honoured in DONE (ignored while busy), held high re-triggers.
//
// Ports:
//   sclk, s_rst            clock, asynchronous active-high reset
//   init_req               re-init request (skips the power-up wait)
//   cmd_reg                {CS_n,RAS_n,CAS_n,WE_n}, registered
//   sdram_addr, sdram_ba   address bus (decoded from cmd_reg), bank address (always 0)
//   flag_init_end          level: sequence complete, shared bus released
//   init_done              single-cycle pulse in the first DONE cycle
//   init_busy              inverse of flag_init_end
module sdram_init_seq #(
  parameter int              PWRUP_CYCLES = 10000,
  parameter int              TRP_CYCLES   = 2,
  parameter int              TRC_CYCLES   = 4,
  parameter int              TMRD_CYCLES  = 2,
  parameter int              AREF_COUNT   = 2,
  parameter int              ADDR_W       = 12,
  parameter int              BA_W         = 2,
  parameter logic [ADDR_W-1:0] MODE_REG   = 'h032
) (
  input  logic              sclk,
  input  logic              s_rst,
  input  logic              init_req,
  output logic [3:0]        cmd_reg,
  output logic [ADDR_W-1:0] sdram_addr,
  output logic [BA_W-1:0]   sdram_ba,
  output logic              flag_init_end,
  output logic              init_done,
  output logic              init_busy
);

  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_PRE  = 4'b0010;
  localparam logic [3:0] CMD_AREF = 4'b0001;
  localparam logic [3:0] CMD_MRS  = 4'b0000;

  localparam int GAP_MAX = (TRP_CYCLES > TRC_CYCLES) ?
                           ((TRP_CYCLES > TMRD_CYCLES) ? TRP_CYCLES : TMRD_CYCLES) :
                           ((TRC_CYCLES > TMRD_CYCLES) ? TRC_CYCLES : TMRD_CYCLES);

  localparam int DLY_W = $clog2(PWRUP_CYCLES + 1);
  localparam int GAP_W = $clog2(GAP_MAX + 1);
  localparam int ARF_W = $clog2(AREF_COUNT + 1);

  localparam logic [DLY_W-1:0] DLY_END  = DLY_W'(PWRUP_CYCLES);
  // Gap counter reads 0 in the command cycle itself, so the next command
  // is due when it reaches (spacing - 1).
  localparam logic [GAP_W-1:0] TRP_END  = GAP_W'(TRP_CYCLES - 1);
  localparam logic [GAP_W-1:0] TRC_END  = GAP_W'(TRC_CYCLES - 1);
  localparam logic [GAP_W-1:0] TMRD_END = GAP_W'(TMRD_CYCLES - 1);
  localparam logic [ARF_W-1:0] ARF_END  = ARF_W'(AREF_COUNT);

  localparam logic [ADDR_W-1:0] A10_ONLY = ADDR_W'(1) << 10;

  typedef enum logic [2:0] {
    S_WAIT, S_PRE, S_TRP, S_AREF, S_TRC, S_MRS, S_TMRD, S_DONE
  } state_t;

  state_t           state;
  logic [DLY_W-1:0] dly_cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic [ARF_W-1:0] aref_cnt;   // number of AREFs already issued

  always_ff @(posedge sclk or posedge s_rst) begin
    if (s_rst) begin
      state         <= S_WAIT;
      dly_cnt       <= '0;
      gap_cnt       <= '0;
      aref_cnt      <= '0;
      cmd_reg       <= CMD_NOP;
      flag_init_end <= 1'b0;
      init_done     <= 1'b0;
    end else begin
      // Commands last exactly one cycle; everything else is NOP.
      cmd_reg   <= CMD_NOP;
      init_done <= 1'b0;
      case (state)
        S_WAIT: begin
          if (dly_cnt == DLY_END) begin
            state    <= S_PRE;
            cmd_reg  <= CMD_PRE;
            dly_cnt  <= '0;
            gap_cnt  <= '0;
            aref_cnt <= '0;
          end else begin
            dly_cnt <= dly_cnt + DLY_W'(1);
          end
        end

        // PRE and its tRP gap form one timed interval.
        S_PRE, S_TRP: begin
          if (gap_cnt == TRP_END) begin
            state    <= S_AREF;
            cmd_reg  <= CMD_AREF;
            gap_cnt  <= '0;
            aref_cnt <= aref_cnt + ARF_W'(1);
          end else begin
            state   <= S_TRP;
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end

        S_AREF, S_TRC: begin
          if (gap_cnt == TRC_END) begin
            gap_cnt <= '0;
            if (aref_cnt == ARF_END) begin
              state   <= S_MRS;
              cmd_reg <= CMD_MRS;
            end else begin
              state    <= S_AREF;
              cmd_reg  <= CMD_AREF;
              aref_cnt <= aref_cnt + ARF_W'(1);
            end
          end else begin
            state   <= S_TRC;
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end

        S_MRS, S_TMRD: begin
          if (gap_cnt == TMRD_END) begin
            state         <= S_DONE;
            gap_cnt       <= '0;
            flag_init_end <= 1'b1;
            init_done     <= 1'b1;
          end else begin
            state   <= S_TMRD;
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end

        // Re-init skips the power-up wait and goes straight to PRE.
        S_DONE: begin
          if (init_req) begin
            state         <= S_PRE;
            cmd_reg       <= CMD_PRE;
            flag_init_end <= 1'b0;
            gap_cnt       <= '0;
            aref_cnt      <= '0;
          end
        end

        default: begin
          state         <= S_WAIT;
          dly_cnt       <= '0;
          gap_cnt       <= '0;
          aref_cnt      <= '0;
          flag_init_end <= 1'b0;
        end
      endcase
    end
  end

  // Address follows the registered command in the same cycle.
  always_comb begin
    sdram_addr = A10_ONLY;
    if (cmd_reg == CMD_MRS) sdram_addr = MODE_REG;
  end

  assign sdram_ba  = '0;
  assign init_busy = ~flag_init_end;

endmodule

// File: tb/tb_sdram_init_seq.sv
// Purpose : directed bench for sdram_init_seq (default and small-parameter instances).
// Latency : cycle c is sampled on the falling edge after the (c+1)-th rising edge post-reset.
// Backpr. : n/a.
module tb_sdram_init_seq;

  localparam logic [3:0] NOP  = 4'b0111;
  localparam logic [3:0] PRE  = 4'b0010;
  localparam logic [3:0] AREF = 4'b0001;
  localparam logic [3:0] MRS  = 4'b0000;

  logic        sclk = 1'b0;
  logic        rst_a, rst_b, req_a, req_b;
  logic [3:0]  cmd_a, cmd_b;
  logic [11:0] addr_a, addr_b;
  logic [1:0]  ba_a, ba_b;
  logic        flag_a, flag_b, done_a, done_b, busy_a, busy_b;

  int n_cmp = 0;
  int n_err = 0;

  always #5 sclk = ~sclk;

  sdram_init_seq dut_a (
    .sclk(sclk), .s_rst(rst_a), .init_req(req_a), .cmd_reg(cmd_a),
    .sdram_addr(addr_a), .sdram_ba(ba_a), .flag_init_end(flag_a),
    .init_done(done_a), .init_busy(busy_a)
  );

  sdram_init_seq #(
    .PWRUP_CYCLES(5), .TRP_CYCLES(1), .TRC_CYCLES(3), .TMRD_CYCLES(1), .AREF_COUNT(8)
  ) dut_b (
    .sclk(sclk), .s_rst(rst_b), .init_req(req_b), .cmd_reg(cmd_b),
    .sdram_addr(addr_b), .sdram_ba(ba_b), .flag_init_end(flag_b),
    .init_done(done_b), .init_busy(busy_b)
  );

  task automatic test_reset;
    rst_a = 1'b1; rst_b = 1'b1; req_a = 1'b0; req_b = 1'b0;
    repeat (3) @(posedge sclk);
    @(negedge sclk);
    n_cmp++; if (cmd_a !== NOP) begin n_err++; $display("FAIL reset_cmd_a got %b want %b", cmd_a, NOP); end
    n_cmp++; if (cmd_b !== NOP) begin n_err++; $display("FAIL reset_cmd_b got %b want %b", cmd_b, NOP); end
    n_cmp++; if (flag_a !== 1'b0) begin n_err++; $display("FAIL reset_flag_a got %b want 0", flag_a); end
    n_cmp++; if (done_a !== 1'b0) begin n_err++; $display("FAIL reset_done_a got %b want 0", done_a); end
    n_cmp++; if (busy_a !== 1'b1) begin n_err++; $display("FAIL reset_busy_a got %b want 1", busy_a); end
    n_cmp++; if (addr_a !== 12'h400) begin n_err++; $display("FAIL reset_addr_a got %h want 400", addr_a); end
    n_cmp++; if (ba_a !== 2'b00 || ba_b !== 2'b00) begin n_err++; $display("FAIL reset_ba got %b/%b want 00", ba_a, ba_b); end
    n_cmp++; if (flag_b !== 1'b0 || done_b !== 1'b0 || busy_b !== 1'b1) begin
      n_err++; $display("FAIL reset_flags_b got f%b d%b b%b want f0 d0 b1", flag_b, done_b, busy_b); end
  endtask

  // Power-up with default parameters; leaves dut_a sampled in DONE at cycle 10013.
  task automatic test_defaults;
    logic [3:0]  exp_cmd;
    logic [11:0] exp_addr;
    rst_a = 1'b0;
    for (int c = 0; c <= 10013; c++) begin
      @(posedge sclk); @(negedge sclk);
      exp_cmd = NOP;
      if (c == 10000) exp_cmd = PRE;
      if (c == 10002 || c == 10006) exp_cmd = AREF;
      if (c == 10010) exp_cmd = MRS;
      exp_addr = (c == 10010) ? 12'h032 : 12'h400;
      n_cmp++; if (cmd_a !== exp_cmd) begin n_err++; $display("FAIL def_cmd c=%0d got %b want %b", c, cmd_a, exp_cmd); end
      n_cmp++; if (addr_a !== exp_addr) begin n_err++; $display("FAIL def_addr c=%0d got %h want %h", c, addr_a, exp_addr); end
      n_cmp++; if (flag_a !== (c >= 10012)) begin n_err++; $display("FAIL def_flag c=%0d got %b", c, flag_a); end
      n_cmp++; if (done_a !== (c == 10012)) begin n_err++; $display("FAIL def_done c=%0d got %b", c, done_a); end
      n_cmp++; if (busy_a !== (c < 10012)) begin n_err++; $display("FAIL def_busy c=%0d got %b", c, busy_a); end
    end
  endtask

  // Single init_req pulse in DONE at cycle R; pulses while busy must be ignored.
  task automatic test_reinit_pulse;
    logic [3:0] exp_cmd;
    req_a = 1'b1;
    for (int j = 1; j <= 16; j++) begin
      @(posedge sclk); @(negedge sclk);
      exp_cmd = NOP;
      if (j == 1) exp_cmd = PRE;
      if (j == 3 || j == 7) exp_cmd = AREF;
      if (j == 11) exp_cmd = MRS;
      n_cmp++; if (cmd_a !== exp_cmd) begin n_err++; $display("FAIL reinit_cmd R+%0d got %b want %b", j, cmd_a, exp_cmd); end
      n_cmp++; if (flag_a !== (j >= 13)) begin n_err++; $display("FAIL reinit_flag R+%0d got %b", j, flag_a); end
      n_cmp++; if (done_a !== (j == 13)) begin n_err++; $display("FAIL reinit_done R+%0d got %b", j, done_a); end
      req_a = (j == 4 || j == 12);
    end
  endtask

  // init_req held high: three back-to-back 13-cycle sequences.
  task automatic test_back_to_back;
    logic [3:0] exp_cmd;
    int k;
    int n_done = 0;
    req_a = 1'b1;
    for (int j = 1; j <= 39; j++) begin
      @(posedge sclk); @(negedge sclk);
      k = (j - 1) % 13 + 1;
      exp_cmd = NOP;
      if (k == 1) exp_cmd = PRE;
      if (k == 3 || k == 7) exp_cmd = AREF;
      if (k == 11) exp_cmd = MRS;
      if (done_a === 1'b1) n_done++;
      n_cmp++; if (cmd_a !== exp_cmd) begin n_err++; $display("FAIL b2b_cmd j=%0d got %b want %b", j, cmd_a, exp_cmd); end
      n_cmp++; if (!(cmd_a inside {NOP, PRE, AREF, MRS})) begin n_err++; $display("FAIL b2b_legal j=%0d got %b", j, cmd_a); end
      n_cmp++; if (flag_a !== (k == 13)) begin n_err++; $display("FAIL b2b_flag j=%0d got %b", j, flag_a); end
    end
    n_cmp++; if (n_done != 3) begin n_err++; $display("FAIL b2b_done_count got %0d want 3", n_done); end
    req_a = 1'b0;
    @(posedge sclk); @(negedge sclk);
    n_cmp++; if (cmd_a !== NOP || flag_a !== 1'b1 || done_a !== 1'b0) begin
      n_err++; $display("FAIL b2b_release got c%b f%b d%b want c0111 f1 d0", cmd_a, flag_a, done_a); end
  endtask

  // Small parameter set on dut_b, then an asynchronous reset in an AREF cycle.
  task automatic test_small_params;
    logic [3:0] exp_cmd;
    int n_aref = 0;
    rst_b = 1'b0;
    for (int c = 0; c <= 33; c++) begin
      @(posedge sclk); @(negedge sclk);
      exp_cmd = NOP;
      if (c == 5) exp_cmd = PRE;
      if (c >= 6 && c <= 27 && (c - 6) % 3 == 0) exp_cmd = AREF;
      if (c == 30) exp_cmd = MRS;
      if (cmd_b === AREF) n_aref++;
      n_cmp++; if (cmd_b !== exp_cmd) begin n_err++; $display("FAIL small_cmd c=%0d got %b want %b", c, cmd_b, exp_cmd); end
      n_cmp++; if (flag_b !== (c >= 31)) begin n_err++; $display("FAIL small_flag c=%0d got %b", c, flag_b); end
      n_cmp++; if (done_b !== (c == 31)) begin n_err++; $display("FAIL small_done c=%0d got %b", c, done_b); end
      if (c == 30) begin
        n_cmp++; if (addr_b !== 12'h032) begin n_err++; $display("FAIL small_mrs_addr got %h want 032", addr_b); end
      end
    end
    n_cmp++; if (n_aref != 8) begin n_err++; $display("FAIL small_aref_count got %0d want 8", n_aref); end
    // Restart, then hit reset between edges while AREF #1 is on the bus.
    rst_b = 1'b1;
    @(negedge sclk);
    rst_b = 1'b0;
    for (int c = 0; c <= 6; c++) begin
      @(posedge sclk); @(negedge sclk);
    end
    n_cmp++; if (cmd_b !== AREF) begin n_err++; $display("FAIL small_pre_async got %b want %b", cmd_b, AREF); end
    #2 rst_b = 1'b1;
    #1;
    n_cmp++; if (cmd_b !== NOP) begin n_err++; $display("FAIL small_async_cmd got %b want %b", cmd_b, NOP); end
    @(negedge sclk);
    rst_b = 1'b0;
    for (int c = 0; c <= 5; c++) begin
      @(posedge sclk); @(negedge sclk);
      exp_cmd = (c == 5) ? PRE : NOP;
      n_cmp++; if (cmd_b !== exp_cmd) begin n_err++; $display("FAIL small_restart c=%0d got %b want %b", c, cmd_b, exp_cmd); end
    end
  endtask

  // Reset in cycle 10004 of a power-up, then the full wait must restart.
  task automatic test_reset_mid;
    logic [3:0] exp_cmd;
    rst_a = 1'b1;
    @(negedge sclk);
    rst_a = 1'b0;
    for (int c = 0; c <= 10003; c++) begin
      @(posedge sclk); @(negedge sclk);
      exp_cmd = NOP;
      if (c == 10000) exp_cmd = PRE;
      if (c == 10002) exp_cmd = AREF;
      n_cmp++; if (cmd_a !== exp_cmd) begin n_err++; $display("FAIL mid_cmd c=%0d got %b want %b", c, cmd_a, exp_cmd); end
    end
    @(posedge sclk);
    #2 rst_a = 1'b1;
    #1;
    n_cmp++; if (cmd_a !== NOP || flag_a !== 1'b0 || done_a !== 1'b0 || busy_a !== 1'b1) begin
      n_err++; $display("FAIL mid_reset got c%b f%b d%b b%b want c0111 f0 d0 b1", cmd_a, flag_a, done_a, busy_a); end
    @(negedge sclk);
    rst_a = 1'b0;
    for (int c = 0; c <= 10002; c++) begin
      @(posedge sclk); @(negedge sclk);
      exp_cmd = NOP;
      if (c == 10000) exp_cmd = PRE;
      if (c == 10002) exp_cmd = AREF;
      n_cmp++; if (cmd_a !== exp_cmd) begin n_err++; $display("FAIL mid_restart c=%0d got %b want %b", c, cmd_a, exp_cmd); end
    end
  endtask

  initial begin
    test_reset();
    test_defaults();
    test_reinit_pulse();
    test_back_to_back();
    test_small_params();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
